// File: rtl/lane_fifo_reader.sv
// rtl/lane_fifo_reader.sv - lane_fifo read-side controller with 2-entry skid buffer
// Optional occupancy output enabled by LANE_FIFO_READER_LEVEL_EN.
module lane_fifo_reader #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] level
);

  logic [ADDR_WIDTH:0]   r_rd_ptr;
  logic                  r_inflight;
  logic                  r_flush_d;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_buf_cnt;

  logic                  w_empty;
  logic                  w_pop;
  logic                  w_discard;
  logic                  w_issue;
  logic [2:0]            w_credit;
  logic [DATA_WIDTH-1:0] w_buf0_n;
  logic [DATA_WIDTH-1:0] w_buf1_n;
  logic [1:0]            w_cnt_n;

  assign read_addr = r_rd_ptr[ADDR_WIDTH-1:0];
  assign rd_ptr    = r_rd_ptr;
  assign out_valid = (r_buf_cnt != 2'd0);
  assign out_data  = r_buf0;

  assign w_empty  = (r_rd_ptr == wr_ptr);
  assign w_pop    = out_valid & out_ready;
  assign w_credit = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

  // The cycle after flush re-syncs to wr_ptr so words committed during flush are dropped too.
  assign w_discard = flush | r_flush_d;
  assign w_issue   = !w_empty && (w_credit < 3'd2) && !w_discard;

  // Pop shifts the head first, then the returning RAM word lands in the first free slot.
  always_comb begin
    w_buf0_n = r_buf0;
    w_buf1_n = r_buf1;
    w_cnt_n  = r_buf_cnt;
    if (w_pop) begin
      w_buf0_n = r_buf1;
      w_cnt_n  = r_buf_cnt - 2'd1;
    end
    if (r_inflight) begin
      if (w_cnt_n == 2'd0) begin
        w_buf0_n = q;
      end else begin
        w_buf1_n = q;
      end
      w_cnt_n = w_cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_flush_d  <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_buf_cnt  <= 2'd0;
    end else begin
      r_flush_d <= flush;
      if (w_discard) begin
        r_rd_ptr   <= wr_ptr;
        r_inflight <= 1'b0;
        r_buf_cnt  <= 2'd0;
      end else begin
        r_rd_ptr   <= w_issue ? r_rd_ptr + 1'b1 : r_rd_ptr;
        r_inflight <= w_issue;
        r_buf0     <= w_buf0_n;
        r_buf1     <= w_buf1_n;
        r_buf_cnt  <= w_cnt_n;
      end
    end
  end

`ifdef LANE_FIFO_READER_LEVEL_EN
  logic [ADDR_WIDTH:0]   w_occ;
  logic [ADDR_WIDTH+1:0] w_level_n;
  logic [ADDR_WIDTH+1:0] r_level;

  assign w_occ     = wr_ptr - r_rd_ptr;
  assign w_level_n = {1'b0, w_occ} + (ADDR_WIDTH+2)'(r_inflight) + (ADDR_WIDTH+2)'(r_buf_cnt);

  always_ff @(posedge clk) begin
    if (reset || w_discard) begin
      r_level <= '0;
    end else begin
      r_level <= w_level_n;
    end
  end

  assign level = r_level;
`else
  assign level = '0;
`endif

endmodule

// File: tb/tb_lane_fifo_reader.sv
// tb/tb_lane_fifo_reader.sv - self-checking bench for lane_fifo_reader
module tb_lane_fifo_reader;
  localparam int DW = 40;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic          push = 1'b0;
  logic [AW:0]   wr_ptr;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] q;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic [AW+1:0] level;

  int            seq;
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] sb [$];
  int            errors = 0;
  int            checks = 0;
  int            n_pops = 0;

  wire [AW:0] occ  = wr_ptr - rd_ptr;
  wire        full = (occ == 10'd512);
  wire        we   = push && !full && !reset;

  lane_fifo_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr_ptr(wr_ptr), .flush(flush),
    .read_addr(read_addr), .q(q), .rd_ptr(rd_ptr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wdat(input int s);
    return 40'h12_3456_789A + 40'(s);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Writer and RAM (registered read with same-address write bypass)
  always @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      seq    <= 0;
    end else if (we) begin
      mem[wr_ptr[AW-1:0]] <= wdat(seq);
      wr_ptr <= wr_ptr + 1'b1;
      seq    <= seq + 1;
    end
    q <= (we && wr_ptr[AW-1:0] == read_addr) ? wdat(seq) : mem[read_addr];
  end

  // Scoreboard: events evaluated at negedge describe what the next posedge does
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("pop_unexpected", 64'd1, 64'd0);
        end else begin
          chk("pop_data", 64'(out_data), 64'(sb[0]));
          sb.delete(0);
        end
        n_pops++;
      end
      if (we) sb.push_back(wdat(seq));
      if (flush) sb.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; flush = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        push;
    logic        rdy;
    logic        exp_valid;
    int          exp_seq;
    logic [AW:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int p0;
    int hold_bad;
    int vcount;
    int run;
    int max_run;
    int cyc;
    int wrap_cnt;
    int max_occ;
    int max_level;
    logic prev_msb;

    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, -1, 10'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, -1, 10'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, -1, 10'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, -1, 10'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, -1, 10'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1,  0, 10'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, -1, 10'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, -1, 10'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, -1, 10'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1,  1, 10'd3};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1,  2, 10'd4};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1,  3, 10'd4};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, -1, 10'd4};

    // Reset state, single-word latency, short burst
    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst; push = tbl[i].push; out_ready = tbl[i].rdy; flush = 1'b0;
      step();
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("v%0d_rd_ptr", i), 64'(rd_ptr), 64'(tbl[i].exp_rd));
      chk($sformatf("v%0d_read_addr", i), 64'(read_addr), 64'(tbl[i].exp_rd[AW-1:0]));
      if (tbl[i].exp_seq >= 0)
        chk($sformatf("v%0d_data", i), 64'(out_data), 64'(wdat(tbl[i].exp_seq)));
      if (tbl[i].rst) begin
        chk($sformatf("v%0d_rst_data", i), 64'(out_data), 64'd0);
        chk($sformatf("v%0d_rst_level", i), 64'(level), 64'd0);
      end
`ifndef LANE_FIFO_READER_LEVEL_EN
      chk($sformatf("v%0d_level_tied", i), 64'(level), 64'd0);
`endif
    end

    // 16 back-to-back words must stream without gaps
    vcount = 0; run = 0; max_run = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      push = (i < 16);
      step();
      if (out_valid) begin
        vcount++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
    push = 1'b0;
    chk("t3_valid_cycles", 64'(vcount), 64'd16);
    chk("t3_longest_run", 64'(max_run), 64'd16);

    // Backpressure: head held stable, only 2 words leave the RAM
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; step();
    end
    push = 1'b0;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(out_valid === 1'b1 && out_data === wdat(0))) hold_bad++;
    end
    chk("t4_hold_stable", 64'(hold_bad), 64'd0);
    chk("t4_rd_ptr", 64'(rd_ptr), 64'd2);
    p0 = n_pops;
    out_ready = 1'b1;
    cyc = 0;
    while (!((n_pops - p0) == 8 && !out_valid) && cyc < 40) begin
      step(); cyc++;
    end
    chk("t4_pops", 64'(n_pops - p0), 64'd8);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Wrap: 1200 words, random ready, writer throttled by full
    do_reset();
    p0 = n_pops; cyc = 0; wrap_cnt = 0; max_occ = 0; max_level = 0;
    prev_msb = rd_ptr[AW];
    while ((n_pops - p0) < 1200 && cyc < 20000) begin
      push = (seq < 1200);
      out_ready = 1'($urandom_range(0, 1));
      step(); cyc++;
      if (rd_ptr[AW] != prev_msb) wrap_cnt++;
      prev_msb = rd_ptr[AW];
      if (int'(occ) > max_occ) max_occ = int'(occ);
      if (int'(level) > max_level) max_level = int'(level);
    end
    push = 1'b0; out_ready = 1'b1;
    chk("t5_pops", 64'(n_pops - p0), 64'd1200);
    chk("t5_rd_ptr_final", 64'(rd_ptr), 64'd176);
    chk("t5_wraps", 64'(wrap_cnt), 64'd2);
    chk("t5_occ_le_full", 64'(max_occ <= 512), 64'd1);
    chk("t5_level_le_514", 64'(max_level <= 514), 64'd1);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with 5 pending and 2 buffered, plus a word committed in the flush cycle
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; step();
    end
    push = 1'b0;
    step(); step(); step();
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    chk("t6_pre_rd_ptr", 64'(rd_ptr), 64'd2);
    flush = 1'b1; push = 1'b1;
    step();
    flush = 1'b0; push = 1'b0;
    chk("t6_valid_after_flush", 64'(out_valid), 64'd0);
    chk("t6_level_after_flush", 64'(level), 64'd0);
    step();
    chk("t6_rd_eq_wr", 64'(rd_ptr), 64'(wr_ptr));
    chk("t6_rd_ptr", 64'(rd_ptr), 64'd8);
    chk("t6_valid_settled", 64'(out_valid), 64'd0);
    chk("t6_level_settled", 64'(level), 64'd0);
    out_ready = 1'b1; push = 1'b1;
    step();
    push = 1'b0;
    chk("t6_new_n", 64'(out_valid), 64'd0);
    step();
    chk("t6_new_n1", 64'(out_valid), 64'd0);
    chk("t6_new_rd_ptr", 64'(rd_ptr), 64'd9);
    step();
    chk("t6_new_n2_valid", 64'(out_valid), 64'd1);
    chk("t6_new_n2_data", 64'(out_data), 64'(wdat(8)));
    step();
    chk("t6_drained", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
